ps2_kb_ctrl: RTL and testbench

PS/2 keyboard front end that feeds the kb_info register in the memory map through the kb_wraddr/kb_wrdata/kb_we write port.
- Receives and checks PS/2 device-to-host frames.
- Folds E0 (extended) and F0 (break) prefixes into one key event.
- Tracks shift and caps-lock state.
- Writes one 32-bit event word per key event, which the CPU polls at KB_INFO_OFFSET.

---
 rtl/ps2_kb_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_ps2_kb_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_kb_ctrl.sv
// PS/2 keyboard front end: synchronizes and glitch-filters the PS/2 pins,
// receives device-to-host frames, folds E0/F0 prefixes into key events,
// tracks shift/caps-lock and writes one 32-bit event word per key event
// into kb_info through the kb_wraddr/kb_wrdata/kb_we port.
// Optional feature macro: PS2_TIMEOUT_EN (inter-edge frame timeout).
module ps2_kb_ctrl #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SEQ_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] kb_wraddr,
    output logic [31:0] kb_wrdata,
    output logic        kb_we,
    output logic [7:0]  kb_err_cnt,
    output logic        rx_busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] CODE_EXT     = 8'hE0;
    localparam logic [7:0] CODE_BRK     = 8'hF0;
    localparam logic [7:0] CODE_LSHIFT  = 8'h12;
    localparam logic [7:0] CODE_RSHIFT  = 8'h59;
    localparam logic [7:0] CODE_CAPS    = 8'h58;

    logic                  r_clk_meta, r_clk_sync;
    logic                  r_dat_meta, r_dat_sync;
    logic [FILTER_LEN-1:0] r_filt_hist;
    logic                  r_clk_filt;
    logic                  w_all_low, w_all_high, w_fall;

    logic [1:0]            r_state, w_state_next;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shreg;
    logic                  r_parity;
    logic                  w_stop_fall, w_frame_ok, w_frame_bad, w_timeout;
    logic                  r_byte_valid;
    logic [7:0]            r_err_cnt;
    logic                  r_rx_busy;

    logic                  r_ext, r_brk;
    logic                  r_shift_l, r_shift_r, r_caps, r_caps_held;
    logic [SEQ_W-1:0]      r_seq;
    logic                  r_we;
    logic [31:0]           r_wrdata;
    logic                  w_is_code;
    logic                  w_shift_l_nx, w_shift_r_nx, w_caps_nx, w_caps_held_nx;

    // Two-flop synchronizers for both PS/2 pins (idle bus level is high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= ps2_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_all_low  = (r_filt_hist == '0);
    assign w_all_high = &r_filt_hist;
    assign w_fall     = r_clk_filt & w_all_low;

    // Glitch filter: filtered clock follows only after FILTER_LEN equal samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt_hist <= '1;
            r_clk_filt  <= 1'b1;
        end else begin
            r_filt_hist <= {r_filt_hist[FILTER_LEN-2:0], r_clk_sync};
            if (w_all_low) begin
                r_clk_filt <= 1'b0;
            end else if (w_all_high) begin
                r_clk_filt <= 1'b1;
            end
        end
    end

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Inter-edge watchdog: restarts on each fall edge, idle and zero in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_IDLE) || w_fall) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
`endif

    // Receive FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Receive FSM next state; advances only on filtered fall edges
    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!r_dat_sync) w_state_next = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
                ST_PARITY: w_state_next = ST_STOP;
                ST_STOP:   w_state_next = ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Frame datapath: bit counter, LSB-first shift register, parity bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= 3'd0;
            r_shreg   <= 8'd0;
            r_parity  <= 1'b0;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: r_bit_cnt <= 3'd0;
                ST_DATA: begin
                    r_shreg   <= {r_dat_sync, r_shreg[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                ST_PARITY: r_parity <= r_dat_sync;
                default: ;
            endcase
        end
    end

    assign w_stop_fall = w_fall && (r_state == ST_STOP) && !w_timeout;
    assign w_frame_ok  = (^{r_shreg, r_parity}) & r_dat_sync;
    assign w_frame_bad = (w_stop_fall & ~w_frame_ok) | w_timeout;

    // Frame result: byte strobe, saturating error count, busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_valid <= 1'b0;
            r_err_cnt    <= 8'd0;
            r_rx_busy    <= 1'b0;
        end else begin
            r_byte_valid <= w_stop_fall & w_frame_ok;
            r_rx_busy    <= (w_state_next != ST_IDLE);
            if (w_frame_bad && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign w_is_code = r_byte_valid && (r_shreg != CODE_EXT) && (r_shreg != CODE_BRK);

    // Modifier state after the current code is applied
    always_comb begin
        w_shift_l_nx   = r_shift_l;
        w_shift_r_nx   = r_shift_r;
        w_caps_nx      = r_caps;
        w_caps_held_nx = r_caps_held;
        if (w_is_code && !r_ext) begin
            if (r_shreg == CODE_LSHIFT) begin
                w_shift_l_nx = !r_brk;
            end
            if (r_shreg == CODE_RSHIFT) begin
                w_shift_r_nx = !r_brk;
            end
            if (r_shreg == CODE_CAPS) begin
                if (r_brk) begin
                    w_caps_held_nx = 1'b0;
                end else begin
                    if (!r_caps_held) begin
                        w_caps_nx = !r_caps;
                    end
                    w_caps_held_nx = 1'b1;
                end
            end
        end
    end

    // Decoder: prefix folding, modifier tracking and event write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_shift_l   <= 1'b0;
            r_shift_r   <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
            r_seq       <= '0;
            r_we        <= 1'b0;
            r_wrdata    <= 32'd0;
        end else begin
            r_we <= 1'b0;
            if (w_frame_bad) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (r_byte_valid) begin
                if (r_shreg == CODE_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_shreg == CODE_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_shift_l   <= w_shift_l_nx;
                    r_shift_r   <= w_shift_r_nx;
                    r_caps      <= w_caps_nx;
                    r_caps_held <= w_caps_held_nx;
                    r_we        <= 1'b1;
                    r_wrdata    <= {16'(r_seq), 4'd0, w_caps_nx,
                                    w_shift_l_nx | w_shift_r_nx,
                                    r_brk, r_ext, r_shreg};
                    r_seq       <= r_seq + SEQ_W'(1);
                    r_ext       <= 1'b0;
                    r_brk       <= 1'b0;
                end
            end
        end
    end

    assign kb_wraddr  = 32'd0;
    assign kb_wrdata  = r_wrdata;
    assign kb_we      = r_we;
    assign kb_err_cnt = r_err_cnt;
    assign rx_busy    = r_rx_busy;

endmodule

// File: tb/tb_ps2_kb_ctrl.sv
// Directed bench for ps2_kb_ctrl: drives PS/2 frames bit by bit and checks
// the event words written to kb_info against hand-computed values.
module tb_ps2_kb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] kb_wraddr;
    logic [31:0] kb_wrdata;
    logic        kb_we;
    logic [7:0]  kb_err_cnt;
    logic        rx_busy;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] evq[$];

    ps2_kb_ctrl #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (2000),
        .SEQ_W          (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .kb_wraddr  (kb_wraddr),
        .kb_wrdata  (kb_wrdata),
        .kb_we      (kb_we),
        .kb_err_cnt (kb_err_cnt),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    // Capture every write strobe cycle; a multi-cycle strobe shows up as extra entries
    always @(negedge clk) begin
        if (!rst && kb_we === 1'b1) evq.push_back(kb_wrdata);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        logic [31:0] obs;
        obs = 'x;
        if (evq.size() > 0) obs = evq.pop_front();
        chk(tag, obs, exp);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (10) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (20) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(posedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        logic [10:0] bits;
        par  = (~^b) ^ bad_par;
        bits = {~bad_stop, par, b, 1'b0};
        send_bits(bits, 11);
        repeat (20) @(posedge clk);
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    initial begin
        logic [10:0] partial;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_we",     32'(kb_we),      32'd0);
        chk("rst_wrdata", kb_wrdata,       32'd0);
        chk("rst_wraddr", kb_wraddr,       32'd0);
        chk("rst_err",    32'(kb_err_cnt), 32'd0);
        chk("rst_busy",   32'(rx_busy),    32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Plain make code
        key(8'h1C);
        chk("t1_cnt", 32'(evq.size()), 32'd1);
        pop_chk("t1_ev", 32'h0000_001C);
        chk("t1_err",    32'(kb_err_cnt), 32'd0);
        chk("t1_wraddr", kb_wraddr,       32'd0);

        // Break, shift make, shifted key, shift break
        key(8'hF0); key(8'h1C);
        key(8'h12); key(8'h1C);
        key(8'hF0); key(8'h12);
        chk("t2_cnt", 32'(evq.size()), 32'd4);
        pop_chk("t2_brk1c",   32'h0001_021C);
        pop_chk("t2_shmake",  32'h0002_0412);
        pop_chk("t2_shift1c", 32'h0003_041C);
        pop_chk("t2_shbrk",   32'h0004_0212);
        chk("t2_hold", kb_wrdata, 32'h0004_0212);

        // Extended break: prefixes produce no writes
        key(8'hE0);
        key(8'hF0);
        chk("t3_noprefix", 32'(evq.size()), 32'd0);
        key(8'h75);
        chk("t3_cnt", 32'(evq.size()), 32'd1);
        pop_chk("t3_ev", 32'h0005_0375);

        // Caps lock with typematic repeats
        key(8'h58); key(8'h58); key(8'h58);
        key(8'hF0); key(8'h58);
        key(8'h58);
        chk("t4_cnt", 32'(evq.size()), 32'd5);
        pop_chk("t4_caps1", 32'h0006_0858);
        pop_chk("t4_rep1",  32'h0007_0858);
        pop_chk("t4_rep2",  32'h0008_0858);
        pop_chk("t4_brk",   32'h0009_0A58);
        pop_chk("t4_caps0", 32'h000A_0058);

        // Bad parity, bad stop, then a good frame
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("t5_nowr", 32'(evq.size()), 32'd0);
        chk("t5_err",  32'(kb_err_cnt), 32'd2);
        key(8'h1C);
        pop_chk("t5_ev", 32'h000B_001C);
        chk("t5_err_keep", 32'(kb_err_cnt), 32'd2);

`ifdef PS2_TIMEOUT_EN
        // Stall after four data bits until the watchdog fires
        partial = 11'b000_0001_1100 << 1;
        send_bits(partial, 5);
        chk("t6_busy", 32'(rx_busy), 32'd1);
        repeat (2100) @(posedge clk);
        #1;
        chk("t6_idle", 32'(rx_busy),    32'd0);
        chk("t6_err",  32'(kb_err_cnt), 32'd3);
        key(8'h1C);
        pop_chk("t6_ev", 32'h000C_001C);
`endif

        // Reset in the middle of a frame
        partial = 11'b000_0001_1100 << 1;
        send_bits(partial, 5);
        #1;
        chk("t7_busy", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t7_we",     32'(kb_we),      32'd0);
        chk("t7_wrdata", kb_wrdata,       32'd0);
        chk("t7_wraddr", kb_wraddr,       32'd0);
        chk("t7_err",    32'(kb_err_cnt), 32'd0);
        chk("t7_busy0",  32'(rx_busy),    32'd0);
        rst = 1'b0;
        repeat (200) @(posedge clk);
        chk("t7_nowr", 32'(evq.size()), 32'd0);
        key(8'h1C);
        chk("t7_cnt", 32'(evq.size()), 32'd1);
        pop_chk("t7_ev", 32'h0000_001C);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
